// File: rtl/collision_pkg.sv
// Shared stage encoding and default tuning constants for the collision stage controller.
package collision_pkg;

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_STAGE1 = 3'd1,
    ST_STAGE2 = 3'd2,
    ST_STAGE3 = 3'd3,
    ST_ENDING = 3'd4
  } stage_t;

  localparam int NUM_STAGES              = 5;
  localparam int DEFAULT_PIXEL_THRESHOLD = 50;
  localparam int DEFAULT_CNT_W           = 10;
  localparam int DEFAULT_HOLD_FRAMES     = 3;

  // Bit i of the result is the enable for stage code i.
  function automatic logic [NUM_STAGES-1:0] stage_onehot(input stage_t s);
    logic [NUM_STAGES-1:0] oh;
    oh = '0;
    case (s)
      ST_START:  oh = 5'b00001;
      ST_STAGE1: oh = 5'b00010;
      ST_STAGE2: oh = 5'b00100;
      ST_STAGE3: oh = 5'b01000;
      ST_ENDING: oh = 5'b10000;
      default:   oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/frame_hit_counter.sv
// Per-frame detected-pixel counter with threshold test and consecutive-hit-frame hold.
module frame_hit_counter
  import collision_pkg::*;
#(
  parameter int PIXEL_THRESHOLD = DEFAULT_PIXEL_THRESHOLD,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int HOLD_FRAMES     = DEFAULT_HOLD_FRAMES
) (
  input  logic clk_25MHz,
  input  logic reset,
  input  logic frame_tick,
  input  logic sel_det,
  input  logic clear,
  input  logic count_en,
  output logic advance
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [4:0]       HOLD_TGT = 5'(HOLD_FRAMES);

  if (PIXEL_THRESHOLD > (2 ** CNT_W) - 1) begin : g_threshold_unreachable
    $error("PIXEL_THRESHOLD exceeds the hit counter range; no frame can ever hit");
  end
  if (HOLD_FRAMES < 1 || HOLD_FRAMES > 15) begin : g_hold_range
    $error("HOLD_FRAMES must be in 1..15");
  end

  logic [CNT_W-1:0] hit_cnt;
  logic [3:0]       hold_cnt;
  logic             frame_hit;
  logic             hold_met;

  // A threshold wider than the counter compares as never reached.
  assign frame_hit = (32'(hit_cnt) >= 32'(PIXEL_THRESHOLD));
  assign hold_met  = (({1'b0, hold_cnt} + 5'd1) == HOLD_TGT);
  assign advance   = frame_tick & count_en & frame_hit & hold_met;

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      hold_cnt <= '0;
    end else if (clear) begin
      hit_cnt  <= '0;
      hold_cnt <= '0;
    end else if (!count_en) begin
      hit_cnt  <= '0;
    end else if (frame_tick) begin
      hit_cnt  <= {{(CNT_W-1){1'b0}}, sel_det};
      hold_cnt <= frame_hit ? hold_cnt + 4'd1 : 4'd0;
    end else if (sel_det && hit_cnt != CNT_MAX) begin
      hit_cnt  <= hit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/collision_stage_controller.sv
// Game stage sequencer: selects the active detector input, drives one-hot collision enables
// and advances START..ENDING on sustained hits. Optional macro: COLLISION_LOCKOUT_EN.
module collision_stage_controller
  import collision_pkg::*;
#(
  parameter int PIXEL_THRESHOLD = DEFAULT_PIXEL_THRESHOLD,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int HOLD_FRAMES     = DEFAULT_HOLD_FRAMES
) (
  input  logic       clk_25MHz,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       collision_detected,
  input  logic       collision_detected1,
  input  logic       collision_detected2,
  input  logic       collision_detected3,
  input  logic       collision_detected_ending,
  output logic       collision_en_start,
  output logic       collision_en1,
  output logic       collision_en2,
  output logic       collision_en3,
  output logic       collision_en_ending,
  output logic [2:0] stage,
  output logic       stage_changed,
  output logic       game_done
);

  stage_t                stage_q;
  stage_t                stage_next;
  logic [NUM_STAGES-1:0] en_q;
  logic                  sel_det;
  logic                  advance;
  logic                  count_en;
  logic                  lockout_next;

`ifdef COLLISION_LOCKOUT_EN
  logic lockout;

  // The frame after an advance is ignored: the detector is still flushing the old stage.
  assign lockout_next = advance | (lockout & ~frame_tick);
  assign count_en     = ~lockout;

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) lockout <= 1'b0;
    else       lockout <= lockout_next;
  end
`else
  assign lockout_next = 1'b0;
  assign count_en     = 1'b1;
`endif

  always_comb begin
    sel_det = 1'b0;
    case (stage_q)
      ST_START:  sel_det = collision_detected;
      ST_STAGE1: sel_det = collision_detected1;
      ST_STAGE2: sel_det = collision_detected2;
      ST_STAGE3: sel_det = collision_detected3;
      ST_ENDING: sel_det = collision_detected_ending;
      default:   sel_det = 1'b0;
    endcase
  end

  frame_hit_counter #(
    .PIXEL_THRESHOLD(PIXEL_THRESHOLD),
    .CNT_W          (CNT_W),
    .HOLD_FRAMES    (HOLD_FRAMES)
  ) u_counter (
    .clk_25MHz (clk_25MHz),
    .reset     (reset),
    .frame_tick(frame_tick),
    .sel_det   (sel_det),
    .clear     (advance),
    .count_en  (count_en),
    .advance   (advance)
  );

  always_comb begin
    stage_next = stage_q;
    case (stage_q)
      ST_START:  if (advance) stage_next = ST_STAGE1;
      ST_STAGE1: if (advance) stage_next = ST_STAGE2;
      ST_STAGE2: if (advance) stage_next = ST_STAGE3;
      ST_STAGE3: if (advance) stage_next = ST_ENDING;
      ST_ENDING: if (advance) stage_next = ST_START;
      default:   stage_next = ST_START;
    endcase
  end

  // Enables are decoded from the next stage so they change in the same cycle as stage.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      stage_q       <= ST_START;
      en_q          <= 5'b00001;
      stage_changed <= 1'b0;
      game_done     <= 1'b0;
    end else begin
      stage_q       <= stage_next;
      en_q          <= lockout_next ? '0 : stage_onehot(stage_next);
      stage_changed <= (stage_next != stage_q);
      game_done     <= advance & (stage_q == ST_ENDING);
    end
  end

  assign stage               = stage_q;
  assign collision_en_start  = en_q[0];
  assign collision_en1       = en_q[1];
  assign collision_en2       = en_q[2];
  assign collision_en3       = en_q[3];
  assign collision_en_ending = en_q[4];

endmodule

// File: tb/tb_collision_stage_controller.sv
// Directed bench for collision_stage_controller: frame-level model plus literal checkpoints.
module tb_collision_stage_controller;

  localparam int THRESH = 50;
  localparam int HOLD   = 3;
`ifdef COLLISION_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [4:0] det = 5'b0;

  always #20 clk = ~clk;

  logic       en0_a, en1_a, en2_a, en3_a, en4_a, chg_a, done_a;
  logic [2:0] stage_a;
  logic       en0_b, en1_b, en2_b, en3_b, en4_b, chg_b, done_b;
  logic [2:0] stage_b;

  collision_stage_controller dut (
    .clk_25MHz(clk), .reset(reset), .frame_tick(tick),
    .collision_detected(det[0]), .collision_detected1(det[1]), .collision_detected2(det[2]),
    .collision_detected3(det[3]), .collision_detected_ending(det[4]),
    .collision_en_start(en0_a), .collision_en1(en1_a), .collision_en2(en2_a),
    .collision_en3(en3_a), .collision_en_ending(en4_a),
    .stage(stage_a), .stage_changed(chg_a), .game_done(done_a)
  );

  collision_stage_controller #(.CNT_W(6)) dut6 (
    .clk_25MHz(clk), .reset(reset), .frame_tick(tick),
    .collision_detected(det[0]), .collision_detected1(det[1]), .collision_detected2(det[2]),
    .collision_detected3(det[3]), .collision_detected_ending(det[4]),
    .collision_en_start(en0_b), .collision_en1(en1_b), .collision_en2(en2_b),
    .collision_en3(en3_b), .collision_en_ending(en4_b),
    .stage(stage_b), .stage_changed(chg_b), .game_done(done_b)
  );

  // ---------------- scoreboard counters ----------------
  int tests  = 0;
  int failed = 0;
  int n_changed = 0;
  int n_done    = 0;
  bit cmp_on    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the game in frame terms: pixels seen this frame, hit frames in a row, stage index.
  int m_stage = 0, m_pix = 0, m_hold = 0;
  bit m_lock = 0, m_changed = 0, m_done = 0, m_adv = 0, m_sel = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_stage = 0; m_pix = 0; m_hold = 0; m_lock = 0; m_changed = 0; m_done = 0;
    end else begin
      m_adv = 0;
      m_sel = det[m_stage];
      if (m_lock) m_pix = 0;
      else if (tick) begin
        if (m_pix >= THRESH) begin
          if (m_hold + 1 == HOLD) m_adv = 1;
          else m_hold++;
        end else m_hold = 0;
        m_pix = int'(m_sel);
      end else m_pix = m_pix + int'(m_sel);
      m_changed = m_adv;
      m_done    = m_adv && (m_stage == 4);
      if (m_adv) begin
        m_stage = (m_stage + 1) % 5;
        m_pix = 0; m_hold = 0; m_lock = LOCK_EN;
      end else if (tick) m_lock = 0;
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      logic [4:0] exp_en;
      exp_en = m_lock ? 5'b0 : 5'(1 << m_stage);
      check("stage",       32'(stage_a), 32'(m_stage));
      check("enables",     32'({en4_a, en3_a, en2_a, en1_a, en0_a}), 32'(exp_en));
      check("stage_changed", 32'(chg_a), 32'(m_changed));
      check("game_done",   32'(done_a), 32'(m_done));
      check("hit_cnt",     32'(dut.u_counter.hit_cnt), 32'(sat(m_pix, 1023)));
      check("stage_w6",    32'(stage_b), 32'(m_stage));
      check("enables_w6",  32'({en4_b, en3_b, en2_b, en1_b, en0_b}), 32'(exp_en));
      check("hit_cnt_w6",  32'(dut6.u_counter.hit_cnt), 32'(sat(m_pix, 63)));
      if (!reset) begin
        if (chg_a)  n_changed++;
        if (done_a) n_done++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_cycles(input logic [4:0] m, input int n);
    repeat (n) begin
      @(negedge clk);
      det = m; tick = 1'b0;
    end
  endtask

  task automatic do_tick(input logic [4:0] m);
    @(negedge clk);
    det = m; tick = 1'b1;
    @(negedge clk);
    det = 5'b0; tick = 1'b0;
  endtask

  task automatic frame(input logic [4:0] m, input int n_pix, input int idle);
    run_cycles(m, n_pix);
    run_cycles(5'b0, idle);
    do_tick(5'b0);
  endtask

  // Three hitting frames on stage s, then one quiet frame that absorbs any lockout.
  task automatic walk(input int s);
    repeat (HOLD) frame(5'(1 << s), 50, 10);
    frame(5'b0, 0, 30);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #5 reset = 1'b1;
    cmp_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_stage", 32'(stage_a), 32'd0);
    check("rst_en", 32'({en4_a, en3_a, en2_a, en1_a, en0_a}), 32'b00001);
    check("rst_hit_cnt", 32'(dut.u_counter.hit_cnt), 32'd0);
    reset = 1'b0;

    repeat (5) frame(5'b0, 0, 60);
    run_cycles(5'b0, 1);
    check("idle_stage", 32'(stage_a), 32'd0);
    check("idle_changes", 32'(n_changed), 32'd0);

    repeat (HOLD) frame(5'b00001, 50, 5);
    check("start_adv_stage", 32'(stage_a), 32'd1);
    run_cycles(5'b0, 1);
    check("start_adv_pulses", 32'(n_changed), 32'd1);
    frame(5'b0, 0, 30);
    check("stage1_en", 32'(en1_a), 32'd1);

    frame(5'b00010, 49, 5);
    frame(5'b00010, 50, 5);
    frame(5'b00010, 50, 5);
    frame(5'b00010, 49, 5);
    frame(5'b00010, 50, 5);
    frame(5'b00010, 50, 5);
    check("hold_reset_stage", 32'(stage_a), 32'd1);
    frame(5'b00010, 50, 5);
    check("hold_adv_stage", 32'(stage_a), 32'd2);
    frame(5'b0, 0, 30);

    repeat (2) begin
      run_cycles(5'b11011, 1000);
      run_cycles(5'b0, 1);
      check("nonsel_hit_cnt", 32'(dut.u_counter.hit_cnt), 32'd0);
      do_tick(5'b0);
    end
    check("nonsel_stage", 32'(stage_a), 32'd2);

    // Pixel on the tick cycle opens the next frame's count.
    run_cycles(5'b00100, 50);
    do_tick(5'b00100);
    check("tick_pixel_cnt", 32'(dut.u_counter.hit_cnt), 32'd1);
    run_cycles(5'b00100, 100);
    run_cycles(5'b0, 1);
    check("sat_cnt_w10", 32'(dut.u_counter.hit_cnt), 32'd101);
    check("sat_cnt_w6", 32'(dut6.u_counter.hit_cnt), 32'd63);
    do_tick(5'b0);
    frame(5'b00100, 100, 2);
    check("sat_adv_stage_w6", 32'(stage_b), 32'd3);
    frame(5'b0, 0, 30);

    walk(3);
    check("stage3_adv", 32'(stage_a), 32'd4);
    walk(4);
    check("ending_wrap_stage", 32'(stage_a), 32'd0);
    check("game_done_pulses", 32'(n_done), 32'd1);

    walk(0);
    walk(1);
    check("rewalk_stage", 32'(stage_a), 32'd2);
    run_cycles(5'b00100, 20);
    @(negedge clk);
    #5 reset = 1'b1;
    #1;
    check("midrst_stage", 32'(stage_a), 32'd0);
    check("midrst_en", 32'({en4_a, en3_a, en2_a, en1_a, en0_a}), 32'b00001);
    check("midrst_hit_cnt", 32'(dut.u_counter.hit_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    frame(5'b00001, 30, 5);
    check("partial_frame_stage", 32'(stage_a), 32'd0);
    walk(0);
    check("post_rst_adv", 32'(stage_a), 32'd1);

    run_cycles(5'b0, 3);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
